sync_frame_rx: RTL
==================

# sync_frame_rx

UART receiver and frame assembler for the clock-synchronisation link. Samples the asynchronous `rx` pin and decodes 8N1 bytes. Packs seven consecutive bytes into one 56-bit frame and pulses `rx_done` when a complete frame is available. Sits directly upstream of the watch core, which consumes the frame's low 52 bits on `rx_done`.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line rate. `CPB = CLK_FREQ/BAUD` is the number of clocks per bit (integer division; 10416 at the defaults).
- `GAP_BITS`, 20, inter-byte timeout in bit times. A partial frame is discarded after `GAP_BITS*CPB` idle clocks.
- `clk` input 1: single system clock; everything is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `rx` input 1: asynchronous serial line, idle high.
- `received_value` output 56: last complete frame. The first byte received occupies [55:48]; the seventh occupies [7:0].
- `rx_done` output 1: one-cycle pulse when `received_value` has just been updated.
- `frame_err` output 1: one-cycle pulse when a stop bit is sampled low.

## Operation
- Input synchroniser: `rx` passes through two flops to give `rx_s`. Both flops reset to 1.
- Bit FSM has four states: IDLE, START, DATA, STOP.
- Bit timing: a baud counter counts 0..limit-1. Bit index is 0..7. A shift register shifts in LSB first.
- IDLE:
  - `rx_s==0` → START, baud counter cleared.
- START: wait `CPB/2` clocks, then resample `rx_s`.
  - Low → DATA, with bit index 0 and the baud counter cleared.
  - High → false start; return to IDLE with no output activity.
- DATA: every `CPB` clocks, sample `rx_s` into the shift register.
  - After bit 7 is sampled → STOP.
- STOP: after `CPB` clocks, sample `rx_s`.
  - High → byte valid.
  - Low → `frame_err` pulse; the partial frame is discarded (byte count cleared).
  - Either way → IDLE at the middle of the stop bit, so back-to-back bytes are accepted.
- Frame assembly: on each valid byte, `frame_buf <= {frame_buf[47:0], byte}` and the byte count (0..6) increments.
  - When the seventh byte is valid: `received_value <= {frame_buf[47:0], byte}`, `rx_done` pulses, and the count returns to 0.
- Gap timeout: a gap counter runs only while in IDLE with byte count > 0. It clears on any start detection.
  - Reaching `GAP_BITS*CPB` clears the byte count.
  - No output pulse is generated on timeout.
  - `received_value` is unchanged on timeout.
- `received_value` holds its value until the next complete frame; partial or errored frames never alter it.
- Reset: all state is cleared regardless of the current FSM state. This includes FSM → IDLE, counters 0, shift register and `frame_buf` 0, and the byte count 0.

## Timing
- Reset values: `received_value`=0, `rx_done`=0, `frame_err`=0.
- Synchroniser latency is 2 clocks from the `rx` edge to `rx_s`.
- Sample points, measured in clocks after the cycle START is entered:
  - Start-bit check at `CPB/2`.
  - Data bit k at `CPB/2 + (k+1)*CPB`.
  - Stop bit at `CPB/2 + 9*CPB`.
- `rx_done` and the `received_value` update occur in the cycle immediately after the seventh stop-bit sample. `rx_done` is high for exactly one cycle.
- `frame_err` is asserted the cycle after the failing stop sample, for one cycle.
- `rx_done` and `frame_err` are never high in the same cycle.
- A stop-bit error on the seventh byte produces `frame_err` only, with no `rx_done`.
- A timeout and a start detection in the same cycle: the start wins. The gap counter clears and the byte count is kept.
- A reset asserted mid-byte or mid-frame aborts it with no pulse.
- After reset is released, a line held low is treated as a new start once IDLE sees `rx_s==0`.

## Test plan
All scenarios use `CLK_FREQ=16`, `BAUD=1` (so `CPB=16`) and `GAP_BITS=20`.
- Reset → `received_value`=0, `rx_done`=0, `frame_err`=0; `rx` held high for 500 clocks → no pulses.
- Send bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77 back-to-back with a 1-bit stop → exactly one `rx_done` pulse, `received_value`=0x11223344556677, pulse 1 cycle after the 7th stop sample.
- 3-clock low glitch on idle `rx` → no state change; then a full frame 0x00..0x06 → `received_value`=0x00010203040506.
- Send 3 bytes, then the 4th with the stop bit low → `frame_err` one pulse. Then a full frame 0xA0..0xA6 → `received_value`=0xA0A1A2A3A4A5A6, with none of the first 3 bytes present.
- Send 4 bytes, idle 400 clocks (> 320), then a full frame 0xB0..0xB6 → a single `rx_done`, `received_value`=0xB0B1B2B3B4B5B6.
- Assert `reset` during the 5th byte's data bits, release, send frame 0xC0..0xC6 → `received_value` is 0 before the frame and 0xC0C1C2C3C4C5C6 after it, with one `rx_done`.

Source files
------------

// File: rtl/sync_frame_rx.sv
// 8N1 UART receiver that packs seven consecutive bytes into a 56-bit frame.
// A partial frame is dropped on a stop-bit error or after an inter-byte idle timeout.
module sync_frame_rx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned GAP_BITS = 20
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rx_i,
    output logic [55:0] received_value_o,
    output logic        rx_done_o,
    output logic        frame_err_o
);

    localparam int unsigned Cpb      = CLK_FREQ / BAUD;
    localparam int unsigned GapLimit = GAP_BITS * Cpb;
    localparam int unsigned BaudW    = $clog2(Cpb + 1);
    localparam int unsigned GapW     = $clog2(GapLimit + 1);

    localparam logic [BaudW-1:0] BitLast  = BaudW'(Cpb - 1);
    localparam logic [BaudW-1:0] HalfLast = BaudW'(Cpb / 2 - 1);
    localparam logic [GapW-1:0]  GapLast  = GapW'(GapLimit - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e             state_q;
    logic [1:0]         sync_q;
    logic               rx_s;
    logic [BaudW-1:0]   baud_q;
    logic [GapW-1:0]    gap_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic [2:0]         byte_cnt_q;
    logic [47:0]        frame_buf_q;   // the six most recent bytes of the frame in progress
    logic [55:0]        received_value_q;
    logic               rx_done_q;
    logic               frame_err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= StIdle;
            baud_q           <= '0;
            gap_q            <= '0;
            bit_idx_q        <= '0;
            shift_q          <= '0;
            byte_cnt_q       <= '0;
            frame_buf_q      <= '0;
            received_value_q <= '0;
            rx_done_q        <= 1'b0;
            frame_err_q      <= 1'b0;
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // A start edge takes priority over an expiring gap timeout.
                    if (!rx_s) begin
                        state_q <= StStart;
                        baud_q  <= '0;
                        gap_q   <= '0;
                    end else if (byte_cnt_q != 3'd0) begin
                        if (gap_q == GapLast) begin
                            byte_cnt_q <= '0;
                            gap_q      <= '0;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                end
                StStart: begin
                    if (baud_q == HalfLast) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s ? StIdle : StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_q == BitLast) begin
                        baud_q    <= '0;
                        shift_q   <= {rx_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StStop: begin
                    if (baud_q == BitLast) begin
                        baud_q  <= '0;
                        state_q <= StIdle;
                        if (rx_s) begin
                            frame_buf_q <= {frame_buf_q[39:0], shift_q};
                            if (byte_cnt_q == 3'd6) begin
                                received_value_q <= {frame_buf_q, shift_q};
                                rx_done_q        <= 1'b1;
                                byte_cnt_q       <= '0;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            byte_cnt_q  <= '0;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign received_value_o = received_value_q;
    assign rx_done_o        = rx_done_q;
    assign frame_err_o      = frame_err_q;

endmodule
